// File: rtl/dmem_pkg.sv
// Shared types and the fill-pattern function for the data-memory sequencer.
// The fill and compare paths both call fill_word so that they cannot disagree.
package dmem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FILL   = 3'd1,
    ST_VERIFY = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    MODE_ZERO  = 2'b00,
    MODE_CONST = 2'b01,
    MODE_ADDR  = 2'b10,
    MODE_INV   = 2'b11
  } mode_t;

  localparam logic [1:0] STRB_BYTE = 2'b00;
  localparam logic [1:0] STRB_HALF = 2'b01;
  localparam logic [1:0] STRB_WORD = 2'b10;

  // Widest supported memory word. Callers truncate the result to DATA_W, which
  // makes the pattern+address sum wrap modulo 2^DATA_W.
  localparam int FILL_W = 64;

  function automatic logic [FILL_W-1:0] fill_word(input mode_t             mode,
                                                  input logic [FILL_W-1:0] pattern,
                                                  input logic [31:0]       addr);
    // NOTE: every path through a combinational case must assign the result
    // (here via default); a missing branch would infer a latch.
    case (mode)
      MODE_ZERO:  fill_word = '0;
      MODE_CONST: fill_word = pattern;
      MODE_ADDR:  fill_word = pattern + FILL_W'(addr);
      default:    fill_word = ~pattern;
    endcase
  endfunction

endpackage

// File: rtl/dmem_rd_chk.sv
// Read-back checker: tracks outstanding reads through an RD_LAT-deep pipeline,
// compares returning data against the expected fill word, keeps the first error.
module dmem_rd_chk
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              issue,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic [DATA_W-1:0] rd_data,
  input  mode_t             mode,
  input  logic [DATA_W-1:0] pattern,
  output logic              error,
  output logic [ADDR_W-1:0] err_addr,
  output logic [DATA_W-1:0] err_data
);

  // Stage 0 lines up with the registered rd_addr0; stage RD_LAT with rd_data.
  logic [RD_LAT:0]   vld;
  logic [ADDR_W-1:0] adr [RD_LAT+1];
  logic [DATA_W-1:0] expected;
  logic              mismatch;

  assign expected = DATA_W'(fill_word(mode, FILL_W'(pattern), 32'(adr[RD_LAT])));
  assign mismatch = vld[RD_LAT] && (rd_data != expected);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       vld <= '0;
    else if (clear) vld <= '0;
    else            vld <= {vld[RD_LAT-1:0], issue};
  end

  // NOTE: the address stages are left unreset on purpose; the reset valid bits
  // already qualify them, and skipping the reset keeps them plain flops.
  always_ff @(posedge clk) begin
    adr[0] <= issue_addr;
    for (int i = 1; i <= RD_LAT; i++) adr[i] <= adr[i-1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      error    <= 1'b0;
      err_addr <= '0;
      err_data <= '0;
    end else if (clear) begin
      error    <= 1'b0;
      err_addr <= '0;
      err_data <= '0;
    end else if (mismatch && !error) begin
      error    <= 1'b1;
      err_addr <= adr[RD_LAT];
      err_data <= rd_data;
    end
  end

endmodule

// File: rtl/dmem_seq_ctrl.sv
// Data-memory sequencer: fills every word with a selected pattern, then
// optionally reads each word back and flags the first mismatch.
module dmem_seq_ctrl
  import dmem_pkg::*;
#(
  parameter int         MEM_DEPTH = 16,
  parameter int         ADDR_W    = $clog2(MEM_DEPTH),
  parameter int         DATA_W    = 32,
  parameter int         RD_LAT    = 1,
  parameter logic [1:0] WORD_STRB = STRB_WORD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] pattern,
  input  logic              verify_en,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] err_addr,
  output logic [DATA_W-1:0] err_data,
  output logic [ADDR_W-1:0] rd_addr0,
  output logic [ADDR_W-1:0] wr_addr0,
  output logic [DATA_W-1:0] wr_din0,
  output logic              we0,
  output logic [1:0]        wr_strb,
  input  logic [DATA_W-1:0] rd_dout0
);

  // Terminal count is explicit so non-power-of-two depths never overrun.
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [2:0]        LAST_DRAIN = 3'(RD_LAT - 1);

  state_t            state;
  mode_t             mode_q;
  logic [DATA_W-1:0] pattern_q;
  logic              verify_q;
  logic [ADDR_W-1:0] cnt;
  logic [2:0]        drain_cnt;
  logic              accept;
  logic              issue;

  assign accept = (state == ST_IDLE) && start;
  assign issue  = (state == ST_VERIFY);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      mode_q    <= MODE_ZERO;
      pattern_q <= '0;
      verify_q  <= 1'b0;
      cnt       <= '0;
      drain_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_addr0  <= '0;
      wr_addr0  <= '0;
      wr_din0   <= '0;
      we0       <= 1'b0;
      wr_strb   <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so the defaults below are
      // simply overridden by later assignments in the same cycle.
      we0      <= 1'b0;
      wr_strb  <= '0;
      wr_din0  <= '0;
      wr_addr0 <= '0;
      rd_addr0 <= '0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            mode_q    <= mode_t'(mode);
            pattern_q <= pattern;
            verify_q  <= verify_en;
            cnt       <= '0;
            busy      <= 1'b1;
            state     <= ST_FILL;
          end
        end
        ST_FILL: begin
          we0      <= 1'b1;
          wr_strb  <= WORD_STRB;
          wr_addr0 <= cnt;
          wr_din0  <= DATA_W'(fill_word(mode_q, FILL_W'(pattern_q), 32'(cnt)));
          if (cnt == LAST_ADDR) begin
            cnt   <= '0;
            state <= verify_q ? ST_VERIFY : ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_VERIFY: begin
          rd_addr0 <= cnt;
          if (cnt == LAST_ADDR) begin
            cnt       <= '0;
            drain_cnt <= '0;
            state     <= ST_DRAIN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == LAST_DRAIN) state <= ST_DONE;
          else                         drain_cnt <= drain_cnt + 1'b1;
        end
        ST_DONE: begin
          // Stay here through the cycle done is visible so a start then is ignored.
          if (!done) begin
            done <= 1'b1;
            busy <= 1'b0;
          end else begin
            done  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  dmem_rd_chk #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_chk (
    .clk        (clk),
    .rst        (rst),
    .clear      (accept),
    .issue      (issue),
    .issue_addr (cnt),
    .rd_data    (rd_dout0),
    .mode       (mode_q),
    .pattern    (pattern_q),
    .error      (error),
    .err_addr   (err_addr),
    .err_data   (err_data)
  );

endmodule

// File: tb/tb_dmem_seq_ctrl.sv
// Directed bench for dmem_seq_ctrl: a 16-word RD_LAT=1 instance and a
// 10-word RD_LAT=3 instance, each with its own behavioural memory.
module tb_dmem_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]  mode      = 2'b00;
  logic [31:0] pattern   = 32'h0;
  logic        verify_en = 1'b0;
  logic        start_a   = 1'b0;
  logic        start_b   = 1'b0;
  logic        fault_en  = 1'b0;
  logic        clr_mon   = 1'b0;

  logic        busy_a, done_a, error_a, we0_a;
  logic [3:0]  err_addr_a, rd_addr0_a, wr_addr0_a;
  logic [31:0] err_data_a, wr_din0_a, rd_dout0_a;
  logic [1:0]  wr_strb_a;

  logic        busy_b, done_b, error_b, we0_b;
  logic [3:0]  err_addr_b, rd_addr0_b, wr_addr0_b;
  logic [31:0] err_data_b, wr_din0_b, rd_dout0_b;
  logic [1:0]  wr_strb_b;

  dmem_seq_ctrl #(.MEM_DEPTH(16), .DATA_W(32), .RD_LAT(1), .WORD_STRB(2'b10)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .mode(mode), .pattern(pattern),
    .verify_en(verify_en), .busy(busy_a), .done(done_a), .error(error_a),
    .err_addr(err_addr_a), .err_data(err_data_a), .rd_addr0(rd_addr0_a),
    .wr_addr0(wr_addr0_a), .wr_din0(wr_din0_a), .we0(we0_a), .wr_strb(wr_strb_a),
    .rd_dout0(rd_dout0_a)
  );

  dmem_seq_ctrl #(.MEM_DEPTH(10), .DATA_W(32), .RD_LAT(3), .WORD_STRB(2'b10)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .mode(mode), .pattern(pattern),
    .verify_en(verify_en), .busy(busy_b), .done(done_b), .error(error_b),
    .err_addr(err_addr_b), .err_data(err_data_b), .rd_addr0(rd_addr0_b),
    .wr_addr0(wr_addr0_b), .wr_din0(wr_din0_b), .we0(we0_b), .wr_strb(wr_strb_b),
    .rd_dout0(rd_dout0_b)
  );

  // Memory A: one-cycle read, optional stuck words 5 (reads 0) and 9 (reads 1).
  logic [31:0] mem_a [16];
  logic [31:0] pipe_a;
  int          wr_cnt_a, strb_bad_a, done_cnt_a;
  logic [15:0] wr_mask_a;

  always @(posedge clk) begin
    if (fault_en && rd_addr0_a == 4'd5)      pipe_a <= 32'h0;
    else if (fault_en && rd_addr0_a == 4'd9) pipe_a <= 32'h1;
    else                                     pipe_a <= mem_a[rd_addr0_a];
    if (clr_mon) begin
      wr_cnt_a   <= 0;
      strb_bad_a <= 0;
      wr_mask_a  <= '0;
      for (int i = 0; i < 16; i++) mem_a[i] <= 32'hCCCC_CCCC;
    end else if (we0_a) begin
      mem_a[wr_addr0_a]     <= wr_din0_a;
      wr_cnt_a              <= wr_cnt_a + 1;
      wr_mask_a[wr_addr0_a] <= 1'b1;
      if (wr_strb_a != 2'b10) strb_bad_a <= strb_bad_a + 1;
    end
  end
  assign rd_dout0_a = pipe_a;

  always @(negedge clk) if (done_a === 1'b1) done_cnt_a <= done_cnt_a + 1;
  initial done_cnt_a = 0;

  // Memory B: three-cycle read; 16 entries so a stray address cannot index out of range.
  logic [31:0] mem_b [16];
  logic [31:0] pipe_b [3];
  int          wr_cnt_b, max_wr_b, max_rd_b;

  always @(posedge clk) begin
    pipe_b[0] <= mem_b[rd_addr0_b];
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
    if (clr_mon) begin
      wr_cnt_b <= 0;
      max_wr_b <= 0;
      max_rd_b <= 0;
      for (int i = 0; i < 16; i++) mem_b[i] <= 32'hFFFF_FFFF;
    end else begin
      if (we0_b) begin
        mem_b[wr_addr0_b] <= wr_din0_b;
        wr_cnt_b          <= wr_cnt_b + 1;
        if (int'(wr_addr0_b) > max_wr_b) max_wr_b <= int'(wr_addr0_b);
      end
      if (int'(rd_addr0_b) > max_rd_b) max_rd_b <= int'(rd_addr0_b);
    end
  end
  assign rd_dout0_b = pipe_b[2];

  int n_checks = 0;
  int n_err    = 0;
  int t_start  = 0;
  int lat;
  int dc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    @(negedge clk) clr_mon = 1'b1;
    @(negedge clk) clr_mon = 1'b0;
  endtask

  // Returns at the negedge after the accepting edge k; t_start records k.
  task automatic launch(input bit sel_b, input logic [1:0] m, input logic [31:0] p,
                        input logic v);
    @(negedge clk);
    mode      = m;
    pattern   = p;
    verify_en = v;
    if (sel_b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    t_start = cyc;
  endtask

  // Returns at the negedge where done is high; latency -1 if it never came.
  task automatic wait_done(input bit sel_b, output int l);
    l = -1;
    for (int i = 0; i < 200 && l < 0; i++) begin
      @(negedge clk);
      if ((sel_b ? done_b : done_a) === 1'b1) l = cyc - t_start;
    end
  endtask

  initial begin
    clr_mon = 1'b1;
    #23;
    check("rst_ctrl", {busy_a, done_a, error_a, we0_a, wr_strb_a, err_addr_a,
                       rd_addr0_a, wr_addr0_a}, 64'h0);
    check("rst_data", {err_data_a, wr_din0_a}, 64'h0);
    @(negedge clk) rst = 1'b1;
    clr_mon = 1'b0;

    // Asynchronous reset in the middle of a fill.
    clear_mon();
    launch(1'b0, 2'b01, 32'hAAAA_5555, 1'b0);
    repeat (5) @(negedge clk);
    check("midfill_we0", we0_a, 64'h1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_ctrl", {busy_a, done_a, error_a, we0_a, wr_strb_a, err_addr_a,
                             rd_addr0_a, wr_addr0_a}, 64'h0);
    check("async_rst_data", {err_data_a, wr_din0_a}, 64'h0);
    @(negedge clk) rst = 1'b1;
    dc = done_cnt_a;
    repeat (30) @(negedge clk);
    check("no_done_after_rst", done_cnt_a - dc, 64'h0);
    check("idle_after_rst", {busy_a, we0_a}, 64'h0);

    // Fill only, constant pattern.
    clear_mon();
    launch(1'b0, 2'b01, 32'hDEAD_BEEF, 1'b0);
    wait_done(1'b0, lat);
    check("fill_latency", lat, 64'd17);
    check("fill_busy_at_done", busy_a, 64'h0);
    check("fill_error", error_a, 64'h0);
    @(negedge clk);
    check("done_one_cycle", done_a, 64'h0);
    check("fill_wr_cnt", wr_cnt_a, 64'd16);
    check("fill_wr_mask", wr_mask_a, 64'hFFFF);
    check("fill_strb", strb_bad_a, 64'h0);
    check("fill_word0", mem_a[0], 64'hDEAD_BEEF);
    check("fill_word15", mem_a[15], 64'hDEAD_BEEF);

    // Pattern plus address, with read-back.
    clear_mon();
    launch(1'b0, 2'b10, 32'h1000_0000, 1'b1);
    wait_done(1'b0, lat);
    check("addr_latency", lat, 64'd34);
    check("addr_error", error_a, 64'h0);
    check("addr_word7", mem_a[7], 64'h1000_0007);
    check("addr_word15", mem_a[15], 64'h1000_000F);
    check("addr_wr_cnt", wr_cnt_a, 64'd16);

    // Stuck words: first mismatch (word 5) must be captured, word 9 ignored.
    fault_en = 1'b1;
    clear_mon();
    launch(1'b0, 2'b11, 32'h0, 1'b1);
    wait_done(1'b0, lat);
    check("fault_latency", lat, 64'd34);
    check("fault_error", error_a, 64'h1);
    check("fault_err_addr", err_addr_a, 64'd5);
    check("fault_err_data", err_data_a, 64'h0);
    check("fault_word9_written", mem_a[9], 64'hFFFF_FFFF);

    // Starts during FILL and during the done cycle must both be ignored.
    clear_mon();
    dc = done_cnt_a;
    launch(1'b0, 2'b11, 32'h0, 1'b1);
    repeat (4) @(negedge clk);
    mode      = 2'b00;
    pattern   = 32'h0000_0001;
    verify_en = 1'b0;
    start_a   = 1'b1;
    @(negedge clk) start_a = 1'b0;
    wait_done(1'b0, lat);
    start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    check("filter_latency", lat, 64'd34);
    check("filter_done_low", done_a, 64'h0);
    repeat (40) @(negedge clk);
    check("filter_no_restart", busy_a, 64'h0);
    check("filter_done_cnt", done_cnt_a - dc, 64'd1);
    check("filter_wr_cnt", wr_cnt_a, 64'd16);
    check("filter_word3", mem_a[3], 64'hFFFF_FFFF);
    check("filter_err_held", {error_a, err_addr_a}, {59'h0, 1'b1, 4'd5});

    // A fresh start in IDLE clears the held error.
    fault_en = 1'b0;
    launch(1'b0, 2'b01, 32'h5A5A_5A5A, 1'b1);
    check("start_clears_error", {error_a, err_addr_a, busy_a}, 64'h1);
    wait_done(1'b0, lat);
    check("clean_latency", lat, 64'd34);
    check("clean_error", error_a, 64'h0);

    // Non-power-of-two depth with a three-cycle read.
    clear_mon();
    launch(1'b1, 2'b00, 32'h1234_5678, 1'b1);
    wait_done(1'b1, lat);
    check("b_latency", lat, 64'd24);
    check("b_error", error_b, 64'h0);
    check("b_max_wr_addr", max_wr_b, 64'd9);
    check("b_max_rd_addr", max_rd_b, 64'd9);
    check("b_wr_cnt", wr_cnt_b, 64'd10);
    check("b_word9", mem_b[9], 64'h0);
    check("b_word10_untouched", mem_b[10], 64'hFFFF_FFFF);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
